// File: rtl/rom_stream.sv
// rom_stream: burst-read ROM replayed as a valid/ready stream.
//
// A one-cycle i_start (accepted only while o_busy is low) captures a base address and a
// length-minus-one. The block then loads one word per cycle into an output register. Each word
// is held until the consumer takes it (o_valid && i_ready). The ROM read is registered, so no
// input reaches an output combinationally; i_ready only steers next-state.
//
// Parameters:
//   FILE       - init file name, kept for interface compatibility; ROM is filled ROM[i] = i
//   ADDR_WIDTH - width of address and length fields
//   WIDTH      - data word width
//   DEPTH      - number of ROM words, 1..2^ADDR_WIDTH
//   WRAP       - 1: addresses wrap modulo DEPTH; 0: addresses >= DEPTH read zero and set o_oor
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   i_start      - burst request (ignored while o_busy)
//   i_base_addr  - first word address, captured with i_start
//   i_len        - burst length minus one, captured with i_start
//   i_ready      - consumer accepts o_data when o_valid && i_ready
//   i_abort      - only with ROM_STREAM_ABORT_EN: kills the burst and drops the pending word
//   o_data       - current word
//   o_valid      - o_data holds an unconsumed word
//   o_last       - final word of the burst (qualifies o_valid)
//   o_oor        - word address was >= DEPTH (qualifies o_valid, WRAP = 0 only)
//   o_busy       - burst running or word still pending
//
// Optional feature: define ROM_STREAM_ABORT_EN to add the i_abort input.

module rom_stream #(
  parameter string       FILE       = "",
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WRAP       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_len,
  input  logic                  i_ready,
`ifdef ROM_STREAM_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_oor,
  output logic                  o_busy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  // ROM storage; contents are fixed at elaboration and untouched by reset.
  logic [WIDTH-1:0] rom [DEPTH];

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      rom[i] = WIDTH'(i);
    end
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  oor_q, oor_d;

  logic                  abort;
  logic                  ld;
  logic                  in_range;
  logic [WIDTH-1:0]      rom_word;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] base_cap;

`ifdef ROM_STREAM_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  // Load a new word whenever running and the output register is empty or being drained.
  assign ld = (state_q == StRun) && (!valid_q || i_ready);

  assign in_range = (32'(addr_q) < DEPTH);
  assign rom_word = in_range ? rom[addr_q[IdxW-1:0]] : '0;

  always_comb begin
    // With WRAP the counter folds back at DEPTH-1; otherwise it runs the full ADDR_WIDTH range
    // and rolls over to 0, which is back inside the ROM.
    if ((WRAP != 0) && (32'(addr_q) == DEPTH - 1)) begin
      addr_inc = '0;
    end else begin
      addr_inc = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    if (WRAP != 0) begin
      base_cap = ADDR_WIDTH'(32'(i_base_addr) % DEPTH);
    end else begin
      base_cap = i_base_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    oor_d   = oor_q;

    if (abort) begin
      // Abort wins over both a pending load and a new start; o_data keeps its last value.
      state_d = StIdle;
      rem_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      oor_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_q) begin
            // Final word of the previous burst still pending; o_busy is high, so no start.
            if (i_ready) begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              oor_d   = 1'b0;
            end
          end else if (i_start) begin
            addr_d  = base_cap;
            rem_d   = i_len;
            state_d = StRun;
          end
        end
        StRun: begin
          if (ld) begin
            data_d  = rom_word;
            valid_d = 1'b1;
            last_d  = (rem_q == '0);
            oor_d   = !in_range && (WRAP == 0);
            addr_d  = addr_inc;
            rem_d   = rem_q - ADDR_WIDTH'(1);
            if (rem_q == '0) begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      oor_q   <= oor_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_oor   = oor_q;
  assign o_busy  = (state_q == StRun) || valid_q;

endmodule

// File: tb/tb_rom_stream.sv
// Bench for rom_stream: two instances (WRAP=0 and WRAP=1) share one stimulus stream.
// Expected words come from a transaction-level model: the list of addresses a burst visits,
// mapped through ROM[i] = i and the out-of-range / modulo rules.

module tb_rom_stream;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW-1:0] i_len = '0;
  logic          i_ready = 1'b0;
  logic          i_abort = 1'b0;

  logic [DW-1:0] d0_data, d1_data;
  logic          d0_valid, d0_last, d0_oor, d0_busy;
  logic          d1_valid, d1_last, d1_oor, d1_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_stream #(
    .FILE       (""),
    .ADDR_WIDTH (AW),
    .WIDTH      (DW),
    .DEPTH      (DEPTH),
    .WRAP       (0)
  ) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .i_ready     (i_ready),
`ifdef ROM_STREAM_ABORT_EN
    .i_abort     (i_abort),
`endif
    .o_data      (d0_data),
    .o_valid     (d0_valid),
    .o_last      (d0_last),
    .o_oor       (d0_oor),
    .o_busy      (d0_busy)
  );

  rom_stream #(
    .FILE       (""),
    .ADDR_WIDTH (AW),
    .WIDTH      (DW),
    .DEPTH      (DEPTH),
    .WRAP       (1)
  ) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .i_ready     (i_ready),
`ifdef ROM_STREAM_ABORT_EN
    .i_abort     (i_abort),
`endif
    .o_data      (d1_data),
    .o_valid     (d1_valid),
    .o_last      (d1_last),
    .o_oor       (d1_oor),
    .o_busy      (d1_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Runs one burst starting at a negedge with the DUTs idle. mode: 0 = ready always high,
  // 1 = random ready, 2 = ready low for 3 cycles while the second word is pending.
  // noise toggles i_start during the burst and forces it high on the final handshake.
  task automatic run_burst(input int base, input int len, input int mode, input bit noise,
                           output int f0, output int l0, output int lo0, output int l1);
    int   ed0[$];
    int   eo0[$];
    int   ed1[$];
    int   idx, stall, budget;
    bit   rdy, pv, pr;
    logic [DW-1:0] hd0, hd1;
    logic hl, ho, ho1;

    for (int k = 0; k <= len; k++) begin
      int a0, a1;
      a0 = (base + k) % 256;
      ed0.push_back(a0 < DEPTH ? a0 : 0);
      eo0.push_back(a0 >= DEPTH ? 1 : 0);
      a1 = ((base % DEPTH) + k) % DEPTH;
      ed1.push_back(a1);
    end
    f0 = -1; l0 = -1; lo0 = -1; l1 = -1;

    chk("idle_before", {d0_busy, d1_busy}, 0);
    i_start = 1'b1;
    i_base_addr = AW'(base);
    i_len = AW'(len);
    i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("start_latency", {d0_valid, d0_busy, d1_valid, d1_busy}, 4'b0101);
    i_start = noise;
    i_base_addr = AW'($urandom);
    i_len = AW'($urandom);
    @(posedge clk); @(negedge clk);

    idx = 0; stall = 0; pv = 1'b0; pr = 1'b0; budget = 0;
    hd0 = '0; hd1 = '0; hl = 1'b0; ho = 1'b0; ho1 = 1'b0;
    while (idx <= len && budget < 300) begin
      chk("valid_in_burst", {d0_valid, d0_busy, d1_valid, d1_busy}, 4'b1111);
      if (pv && !pr) begin
        chk("hold", {d0_data, d0_last, d0_oor, d1_data, d1_oor}, {hd0, hl, ho, hd1, ho1});
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(idx == 1 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      i_ready = rdy;
      i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (d0_valid && rdy) begin
        chk("word_wrap0", {d0_data, d0_last, d0_oor},
            {DW'(ed0[idx]), (idx == len), 1'(eo0[idx])});
        chk("word_wrap1", {d1_data, d1_last, d1_oor},
            {DW'(ed1[idx]), (idx == len), 1'b0});
        if (idx == 0) f0 = int'(d0_data);
        if (idx == len) begin
          l0 = int'(d0_data);
          lo0 = int'(d0_oor);
          l1 = int'(d1_data);
          if (noise) i_start = 1'b1;
        end
        idx++;
      end
      pv = d0_valid; pr = rdy;
      hd0 = d0_data; hl = d0_last; ho = d0_oor; hd1 = d1_data; ho1 = d1_oor;
      @(posedge clk); @(negedge clk);
      budget++;
    end
    chk("burst_complete", idx, len + 1);
    chk("busy_after", {d0_busy, d0_valid, d1_busy, d1_valid}, 0);
    i_start = 1'b0;
    i_ready = 1'b0;
  endtask

  typedef struct {
    int base;
    int len;
    int mode;
    bit noise;
    int f0;   // first word, WRAP=0
    int l0;   // last word, WRAP=0
    int lo0;  // o_oor on last word, WRAP=0
    int l1;   // last word, WRAP=1
  } vec_t;

  vec_t tbl[6];

  initial begin
    int f0, l0, lo0, l1;

    tbl[0] = '{base: 5,   len: 3, mode: 0, noise: 1'b0, f0: 'h05, l0: 'h08, lo0: 0, l1: 'h08};
    tbl[1] = '{base: 5,   len: 3, mode: 2, noise: 1'b0, f0: 'h05, l0: 'h08, lo0: 0, l1: 'h08};
    tbl[2] = '{base: 62,  len: 3, mode: 0, noise: 1'b0, f0: 'h3e, l0: 'h00, lo0: 1, l1: 'h01};
    tbl[3] = '{base: 250, len: 9, mode: 1, noise: 1'b1, f0: 'h00, l0: 'h03, lo0: 0, l1: 'h03};
    tbl[4] = '{base: 0,   len: 0, mode: 0, noise: 1'b1, f0: 'h00, l0: 'h00, lo0: 0, l1: 'h00};
    tbl[5] = '{base: 63,  len: 0, mode: 0, noise: 1'b0, f0: 'h3f, l0: 'h3f, lo0: 0, l1: 'h3f};

    repeat (2) @(negedge clk);
    chk("reset_state", {d0_data, d0_valid, d0_last, d0_oor, d0_busy,
                        d1_data, d1_valid, d1_last, d1_oor, d1_busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      run_burst(tbl[t].base, tbl[t].len, tbl[t].mode, tbl[t].noise, f0, l0, lo0, l1);
      chk("tbl_first0", f0, tbl[t].f0);
      chk("tbl_last0", l0, tbl[t].l0);
      chk("tbl_last_oor0", lo0, tbl[t].lo0);
      chk("tbl_last1", l1, tbl[t].l1);
    end

    // Asynchronous reset in the middle of a burst, between clock edges.
    i_start = 1'b1; i_base_addr = 8'd10; i_len = 8'd20; i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_burst_active", {d0_valid, d0_busy}, 2'b11);
    rst = 1'b1;
    #1;
    chk("async_reset", {d0_data, d0_valid, d0_last, d0_oor, d0_busy,
                        d1_data, d1_valid, d1_last, d1_oor, d1_busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    i_ready = 1'b0;
    @(negedge clk);
    run_burst(0, 0, 0, 1'b0, f0, l0, lo0, l1);
    chk("post_reset_word", {f0[7:0], l0[7:0], l1[7:0]}, 24'h000000);

`ifdef ROM_STREAM_ABORT_EN
    // Abort on the third word of a 10-word burst, with a simultaneous start request.
    i_start = 1'b1; i_base_addr = 8'd0; i_len = 8'd9; i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    chk("abort_third_word", {d0_valid, d0_data}, {1'b1, 8'h02});
    i_abort = 1'b1; i_start = 1'b1; i_base_addr = 8'd7; i_len = 8'd1;
    @(posedge clk); @(negedge clk);
    i_abort = 1'b0; i_start = 1'b0;
    chk("abort_clears", {d0_valid, d0_last, d0_oor, d0_busy, d1_valid, d1_busy}, 0);
    chk("abort_holds_data", d0_data, 8'h02);
    @(posedge clk); @(negedge clk);
    chk("abort_start_ignored", {d0_valid, d0_busy, d1_valid, d1_busy}, 0);
    i_ready = 1'b0;
`endif

    // Randomized bursts against the address-list model.
    for (int r = 0; r < 40; r++) begin
      run_burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), f0, l0, lo0, l1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
